// File: rtl/cp0_unit_pkg.sv
// cp0_defs: shared constants for the CP0 block.
//   - CP0 register indices (SR, Cause, EPC, PrID)
//   - SR and Cause bit positions
//   - exception handler entry address
//   - exception codes carried down the pipeline
//   - epc_for(): restart PC for a trapping instruction
package cp0_defs;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   // SR fields
   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int SR_IM_LO = 10;
   localparam int SR_IM_HI = 15;

   // Cause fields
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD     = 31;

   // Where the PC logic redirects fetch when Req is raised
   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // A delay-slot instruction restarts at its branch, one word earlier.
   // The subtraction wraps modulo 2^32.
   function automatic logic [31:0] epc_for(input logic [31:0] pc, input logic ds);
      return ds ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: M-stage <-> CP0 signal bundle.
//   master : pipeline side (drives pc/exception/mtc0/eret, receives rdata/Req/EPC)
//   slave  : CP0 side
interface cp0_unit_if;
   logic [31:0] pc_in;
   logic        Delaycheck_in;
   logic [4:0]  ExcCode_in;
   logic [5:0]  HWInt;
   logic        CP0_Wr;
   logic [4:0]  CP0_addr;
   logic [31:0] CP0_wdata;
   logic        eret;
   logic [31:0] CP0_rdata;
   logic        Req;
   logic [31:0] EPC_out;

   modport master (
      output pc_in, Delaycheck_in, ExcCode_in, HWInt,
             CP0_Wr, CP0_addr, CP0_wdata, eret,
      input  CP0_rdata, Req, EPC_out
   );

   modport slave (
      input  pc_in, Delaycheck_in, ExcCode_in, HWInt,
             CP0_Wr, CP0_addr, CP0_wdata, eret,
      output CP0_rdata, Req, EPC_out
   );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: Coprocessor 0 at the M stage of the five-stage MIPS pipeline.
//   Holds SR (12), Cause (13), EPC (14) and the constant PrID (15).
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears SR/Cause/EPC and forces Req low
//   bus   - cp0_unit_if.slave:
//           pc_in, Delaycheck_in, ExcCode_in, HWInt  (M-stage trap inputs)
//           CP0_Wr, CP0_addr, CP0_wdata, eret        (mtc0 / eret at M)
//           CP0_rdata (comb read of CP0_addr), Req (comb flush), EPC_out (reg)
import cp0_defs::*;

module cp0_unit #(
   parameter logic [31:0] PRID = 32'h2021_0707
) (
   input  logic        clk,
   input  logic        reset,
   cp0_unit_if.slave   bus
);

   // SR fields
   logic [5:0]  im_reg;
   logic        exl_reg;
   logic        ie_reg;
   // Cause fields
   logic        bd_reg;
   logic [5:0]  ip_reg;
   logic [4:0]  exc_code_reg;
   // EPC
   logic [31:0] epc_reg;

   logic        int_req;
   logic        exc_req;
   logic        req;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   // EXL masks everything, so a handler is never re-entered.
   assign int_req = (|(bus.HWInt & im_reg)) & ie_reg & ~exl_reg;
   assign exc_req = (bus.ExcCode_in != 5'd0) & ~exl_reg;
   // Req is combinational so the pipeline registers flush on the very
   // edge that records EPC.
   assign req     = (int_req | exc_req) & ~reset;

   always_comb begin
      sr_val                     = '0;
      sr_val[SR_IM_HI:SR_IM_LO]  = im_reg;
      sr_val[SR_EXL]             = exl_reg;
      sr_val[SR_IE]              = ie_reg;
   end

   always_comb begin
      cause_val                            = '0;
      cause_val[CAUSE_BD]                  = bd_reg;
      cause_val[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_reg;
      cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_reg;
   end

   always_comb begin
      case (bus.CP0_addr)
         CP0_SR:    bus.CP0_rdata = sr_val;
         CP0_CAUSE: bus.CP0_rdata = cause_val;
         CP0_EPC:   bus.CP0_rdata = epc_reg;
         CP0_PRID:  bus.CP0_rdata = PRID;
         default:   bus.CP0_rdata = 32'd0;
      endcase
   end

   assign bus.Req     = req;
   assign bus.EPC_out = epc_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         im_reg       <= '0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         ip_reg       <= '0;
         exc_code_reg <= '0;
         epc_reg      <= '0;
      end else begin
         // Pending lines are sampled every cycle, trap or not.
         ip_reg <= bus.HWInt;
         if (req) begin
            // Trap entry: any mtc0/eret in this cycle belongs to a
            // flushed instruction and is dropped.
            exl_reg      <= 1'b1;
            exc_code_reg <= int_req ? 5'(EXC_INT) : bus.ExcCode_in;
            bd_reg       <= bus.Delaycheck_in;
            epc_reg      <= epc_for(bus.pc_in, bus.Delaycheck_in);
         end else begin
            if (bus.eret) begin
               exl_reg <= 1'b0;
            end
            if (bus.CP0_Wr) begin
               case (bus.CP0_addr)
                  CP0_SR: begin
                     im_reg  <= bus.CP0_wdata[SR_IM_HI:SR_IM_LO];
                     exl_reg <= bus.CP0_wdata[SR_EXL];
                     ie_reg  <= bus.CP0_wdata[SR_IE];
                  end
                  CP0_EPC: epc_reg <= bus.CP0_wdata;
                  // Cause and PrID are read-only
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

   localparam logic [31:0] PRID_VAL = 32'h2021_0707;

   logic clk;
   logic reset;
   cp0_unit_if bus();

   cp0_unit #(.PRID(PRID_VAL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [4:0]  exc;
      logic [31:0] pc;
      logic        ds;
      logic [5:0]  hw;
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic        er;
      logic        req;     // expected Req before the edge
      logic [31:0] sr;      // expected registers after the edge
      logic [31:0] cause;
      logic [31:0] epc;
   } vec_t;

   localparam int NVEC = 17;
   vec_t tbl [NVEC];

   task automatic idle_inputs();
      bus.ExcCode_in    = 5'd0;
      bus.pc_in         = 32'h0000_3000;
      bus.Delaycheck_in = 1'b0;
      bus.HWInt         = 6'd0;
      bus.CP0_Wr        = 1'b0;
      bus.CP0_addr      = 5'd0;
      bus.CP0_wdata     = 32'd0;
      bus.eret          = 1'b0;
   endtask

   task automatic run_vec(input int i);
      @(negedge clk);
      bus.ExcCode_in    = tbl[i].exc;
      bus.pc_in         = tbl[i].pc;
      bus.Delaycheck_in = tbl[i].ds;
      bus.HWInt         = tbl[i].hw;
      bus.CP0_Wr        = tbl[i].wr;
      bus.CP0_addr      = tbl[i].addr;
      bus.CP0_wdata     = tbl[i].wdata;
      bus.eret          = tbl[i].er;
      #1;
      chk("vec_req", i, {31'd0, bus.Req}, {31'd0, tbl[i].req});
      @(posedge clk);
      #1;
      bus.CP0_Wr     = 1'b0;
      bus.eret       = 1'b0;
      bus.ExcCode_in = 5'd0;
      bus.CP0_addr   = 5'd12;
      #1 chk("vec_sr", i, bus.CP0_rdata, tbl[i].sr);
      bus.CP0_addr   = 5'd13;
      #1 chk("vec_cause", i, bus.CP0_rdata, tbl[i].cause);
      bus.CP0_addr   = 5'd14;
      #1 chk("vec_epc", i, bus.CP0_rdata, tbl[i].epc);
      chk("vec_epc_out", i, bus.EPC_out, tbl[i].epc);
      $display("vec %0d exc=%0d pc=%h hw=%b wr=%0d eret=%0d -> sr=%h cause=%h epc=%h",
               i, tbl[i].exc, tbl[i].pc, tbl[i].hw, tbl[i].wr, tbl[i].er,
               tbl[i].sr, tbl[i].cause, tbl[i].epc);
   endtask

   // ---------------- reference model (32-bit register images) ----------------
   logic [31:0] m_sr, m_cause, m_epc;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID_VAL;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_int(input logic [5:0] hw);
      logic [5:0] im;
      im = 6'((m_sr >> 10) & 32'h3F);
      return ((hw & im) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_exc(input logic [4:0] exc);
      return (exc != 5'd0) && !m_sr[1];
   endfunction

   task automatic m_edge(input logic rst, input logic [4:0] exc, input logic [31:0] pc,
                         input logic ds, input logic [5:0] hw, input logic wr,
                         input logic [4:0] a, input logic [31:0] wd, input logic er);
      logic ir, r;
      logic [4:0] code;
      ir = m_int(hw);
      r  = (ir || m_exc(exc)) && !rst;
      if (rst) begin
         m_sr = 0; m_cause = 0; m_epc = 0;
      end else if (r) begin
         code    = ir ? 5'd0 : exc;
         m_sr    = m_sr | 32'h2;
         m_cause = (32'(ds) << 31) | (32'(hw) << 10) | (32'(code) << 2);
         m_epc   = ds ? pc - 32'd4 : pc;
      end else begin
         m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
         if (er) m_sr = m_sr & ~32'h2;
         if (wr && a == 5'd12) m_sr  = wd & 32'h0000_FC03;
         if (wr && a == 5'd14) m_epc = wd;
      end
   endtask

   initial begin
      //           exc    pc            ds hw       wr addr   wdata         er req sr            cause         epc
      tbl[0]  = '{5'd12, 32'h0000_3010, 0, 6'd0,  0, 5'd0,  32'h0,        0, 1, 32'h0000_0002, 32'h0000_0030, 32'h0000_3010};
      tbl[1]  = '{5'd0,  32'h0000_3014, 0, 6'd0,  0, 5'd0,  32'h0,        1, 0, 32'h0000_0000, 32'h0000_0030, 32'h0000_3010};
      tbl[2]  = '{5'd10, 32'h0000_3014, 1, 6'd0,  0, 5'd0,  32'h0,        0, 1, 32'h0000_0002, 32'h8000_0028, 32'h0000_3010};
      tbl[3]  = '{5'd0,  32'h0000_3018, 0, 6'd0,  0, 5'd0,  32'h0,        1, 0, 32'h0000_0000, 32'h8000_0028, 32'h0000_3010};
      tbl[4]  = '{5'd0,  32'h0000_301C, 0, 6'd0,  1, 5'd12, 32'h0000_0401, 0, 0, 32'h0000_0401, 32'h8000_0028, 32'h0000_3010};
      tbl[5]  = '{5'd0,  32'h0000_3100, 0, 6'd1,  0, 5'd0,  32'h0,        0, 1, 32'h0000_0403, 32'h0000_0400, 32'h0000_3100};
      tbl[6]  = '{5'd0,  32'h0000_4180, 0, 6'd1,  0, 5'd0,  32'h0,        1, 0, 32'h0000_0401, 32'h0000_0400, 32'h0000_3100};
      tbl[7]  = '{5'd0,  32'h0000_3200, 0, 6'd1,  1, 5'd14, 32'h0000_5000, 1, 1, 32'h0000_0403, 32'h0000_0400, 32'h0000_3200};
      tbl[8]  = '{5'd0,  32'h0000_4184, 0, 6'd0,  0, 5'd0,  32'h0,        1, 0, 32'h0000_0401, 32'h0000_0000, 32'h0000_3200};
      tbl[9]  = '{5'd0,  32'h0000_3204, 0, 6'd0,  1, 5'd12, 32'hFFFF_FC00, 0, 0, 32'h0000_FC00, 32'h0000_0000, 32'h0000_3200};
      tbl[10] = '{5'd0,  32'h0000_3208, 0, 6'd1,  0, 5'd0,  32'h0,        0, 0, 32'h0000_FC00, 32'h0000_0400, 32'h0000_3200};
      tbl[11] = '{5'd0,  32'h0000_320C, 0, 6'd0,  1, 5'd12, 32'h0000_FC01, 0, 0, 32'h0000_FC01, 32'h0000_0000, 32'h0000_3200};
      tbl[12] = '{5'd4,  32'h0000_3300, 0, 6'd2,  0, 5'd0,  32'h0,        0, 1, 32'h0000_FC03, 32'h0000_0800, 32'h0000_3300};
      tbl[13] = '{5'd12, 32'h0000_3400, 0, 6'd2,  0, 5'd0,  32'h0,        0, 0, 32'h0000_FC03, 32'h0000_0800, 32'h0000_3300};
      tbl[14] = '{5'd0,  32'h0000_3404, 0, 6'd0,  1, 5'd13, 32'hFFFF_FFFF, 0, 0, 32'h0000_FC03, 32'h0000_0000, 32'h0000_3300};
      tbl[15] = '{5'd0,  32'h0000_3408, 0, 6'd0,  0, 5'd0,  32'h0,        1, 0, 32'h0000_FC01, 32'h0000_0000, 32'h0000_3300};
      tbl[16] = '{5'd5,  32'h0000_0000, 1, 6'd0,  0, 5'd0,  32'h0,        0, 1, 32'h0000_FC03, 32'h8000_0014, 32'hFFFF_FFFC};

      // ---------- reset state ----------
      reset = 1'b1;
      idle_inputs();
      bus.ExcCode_in = 5'd12;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 0, {31'd0, bus.Req}, 32'd0);
      bus.CP0_addr = 5'd12;
      #1 chk("rst_sr", 0, bus.CP0_rdata, 32'd0);
      bus.CP0_addr = 5'd13;
      #1 chk("rst_cause", 0, bus.CP0_rdata, 32'd0);
      bus.CP0_addr = 5'd14;
      #1 chk("rst_epc", 0, bus.CP0_rdata, 32'd0);
      chk("rst_epc_out", 0, bus.EPC_out, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();

      // ---------- directed table ----------
      for (int i = 0; i < NVEC; i++) run_vec(i);

      // ---------- reset mid-operation (EXL = 1, EPC = FFFFFFFC) ----------
      @(negedge clk);
      reset          = 1'b1;
      bus.ExcCode_in = 5'd12;
      bus.HWInt      = 6'd1;
      #1 chk("midrst_req", 0, {31'd0, bus.Req}, 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_req_after", 0, {31'd0, bus.Req}, 32'd0);
      bus.CP0_addr = 5'd12;
      #1 chk("midrst_sr", 0, bus.CP0_rdata, 32'd0);
      bus.CP0_addr = 5'd13;
      #1 chk("midrst_cause", 0, bus.CP0_rdata, 32'd0);
      chk("midrst_epc_out", 0, bus.EPC_out, 32'd0);
      $display("midrst: reset with pending exception and interrupt");
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      bus.CP0_addr = 5'd15;
      #1 chk("prid", 0, bus.CP0_rdata, PRID_VAL);
      bus.CP0_addr = 5'd3;
      #1 chk("unmapped", 0, bus.CP0_rdata, 32'd0);
      $display("reads: prid and unmapped index");

      // ---------- randomized run against the model ----------
      m_sr = 0; m_cause = 0; m_epc = 0;
      for (int k = 0; k < 400; k++) begin
         logic        r_rst, r_ds, r_wr, r_er, exp_req;
         logic [4:0]  r_exc, r_addr;
         logic [31:0] r_pc, r_wd;
         logic [5:0]  r_hw;
         int          op;
         @(negedge clk);
         r_rst = ($urandom_range(0, 49) == 0);
         case ($urandom_range(0, 7))
            0: r_exc = 5'd4;
            1: r_exc = 5'd10;
            2: r_exc = 5'(1 + $urandom_range(0, 30));
            default: r_exc = 5'd0;
         endcase
         r_pc = $urandom;
         if ($urandom_range(0, 9) == 0) r_pc = 32'($urandom_range(0, 3));
         r_ds = 1'($urandom_range(0, 1));
         r_hw = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         op   = $urandom_range(0, 5);
         r_wr = (op == 0);
         r_er = (op == 1);
         case ($urandom_range(0, 5))
            0: r_addr = 5'd12;
            1: r_addr = 5'd13;
            2: r_addr = 5'd14;
            3: r_addr = 5'd15;
            4: r_addr = 5'd12;
            default: r_addr = 5'($urandom);
         endcase
         r_wd = $urandom;
         reset             = r_rst;
         bus.ExcCode_in    = r_exc;
         bus.pc_in         = r_pc;
         bus.Delaycheck_in = r_ds;
         bus.HWInt         = r_hw;
         bus.CP0_Wr        = r_wr;
         bus.CP0_addr      = r_addr;
         bus.CP0_wdata     = r_wd;
         bus.eret          = r_er;
         #1;
         exp_req = (m_int(r_hw) || m_exc(r_exc)) && !r_rst;
         chk("rnd_req", k, {31'd0, bus.Req}, {31'd0, exp_req});
         chk("rnd_rdata", k, bus.CP0_rdata, m_read(r_addr));
         @(posedge clk);
         m_edge(r_rst, r_exc, r_pc, r_ds, r_hw, r_wr, r_addr, r_wd, r_er);
         #1;
         chk("rnd_epc_out", k, bus.EPC_out, m_epc);
         $display("rnd %0d rst=%0d exc=%0d hw=%b wr=%0d eret=%0d req=%0d sr=%h epc=%h",
                  k, r_rst, r_exc, r_hw, r_wr, r_er, exp_req, m_sr, m_epc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
